gpio_input: RTL

GPIO_INPUT -- requirements
Module: gpio_input

---
 rtl/gpio_input.sv | 120 ++++++++++++
 1 files changed

// File: rtl/gpio_input.sv
// rtl/gpio_input.sv - debounced GPIO input port with edge-triggered pending bits and level irq
// Each pin is synchronized, debounced, and can latch rise/fall events into a W1C pending register.
module gpio_input #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins_in,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_IN      = 2'd0;
  localparam logic [1:0] ADDR_RISE_EN = 2'd1;
  localparam logic [1:0] ADDR_FALL_EN = 2'd2;
  localparam logic [1:0] ADDR_PENDING = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_next;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];

  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;
  logic [WIDTH-1:0] pend_clr;
  logic [WIDTH-1:0] wr_bits;
  logic [31:0]      rd_mux;
  logic             unused_wr;

  assign wr_bits   = wr_data[WIDTH-1:0];
  assign unused_wr = ^wr_data;

  // A bit accepts a new level only after sync2 has differed from stable for DEBOUNCE_CYCLES samples.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise_evt = stable_next & ~stable & rise_en;
  assign fall_evt = ~stable_next & stable & fall_en;

  // New events are OR'd in after the clear so a same-cycle set wins.
  always_comb begin
    pend_clr = '0;
    if (wr_en && addr == ADDR_PENDING) begin
      pend_clr = wr_bits;
    end
    pending_next = (pending & ~pend_clr) | rise_evt | fall_evt;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_IN:      rd_mux[WIDTH-1:0] = stable;
      ADDR_RISE_EN: rd_mux[WIDTH-1:0] = rise_en;
      ADDR_FALL_EN: rd_mux[WIDTH-1:0] = fall_en;
      default:      rd_mux[WIDTH-1:0] = pending;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt    <= '{default: '0};
    end else begin
      sync1  <= pins_in;
      sync2  <= sync1;
      stable <= stable_next;
      cnt    <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_en <= '0;
      fall_en <= '0;
      pending <= '0;
      rd_data <= '0;
    end else begin
      pending <= pending_next;
      if (wr_en && addr == ADDR_RISE_EN) begin
        rise_en <= wr_bits;
      end
      if (wr_en && addr == ADDR_FALL_EN) begin
        fall_en <= wr_bits;
      end
      if (rd_en) begin
        rd_data <= rd_mux;
      end
    end
  end

  assign irq = |pending;

endmodule
